// File: rtl/fp_add.sv
// Pipelined IEEE-754 binary32 adder/subtractor with fixed latency LAT (default `FP_ADD_LAT).
// Define FP_ADD_DENORM_EN for gradual underflow; otherwise denormals flush to signed zero.
`timescale 1ns/1ps
`ifndef FP_ADD_LAT
`define FP_ADD_LAT 3
`endif

module fp_add #(
    parameter int LAT = `FP_ADD_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        en,
    output logic [31:0] y,
    output logic        valid
);

    // Handshake: en is a valid tag with no back-pressure; the pipeline always
    // advances, and valid pulses for one cycle exactly LAT cycles after en.

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // ---------------- stage 1: unpack, specials, swap, align ----------------
    logic        sa, sbe;
    logic [7:0]  ea, eb, ea_eff, eb_eff;
    logic [23:0] ma, mb;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic        a_ge_b;
    logic        sl;
    logic [7:0]  el, es, d;
    logic [23:0] ml, ms;
    logic [53:0] sh_w;
    logic [26:0] ms_al;
    logic        special;
    logic [31:0] spec_val;

    always_comb begin
        sa  = a[31];
        sbe = b[31] ^ sub;
        ea  = a[30:23];
        eb  = b[30:23];
        nan_a = (&ea) && (|a[22:0]);
        nan_b = (&eb) && (|b[22:0]);
        inf_a = (&ea) && !(|a[22:0]);
        inf_b = (&eb) && !(|b[22:0]);
`ifdef FP_ADD_DENORM_EN
        ea_eff = (ea == 8'd0) ? 8'd1 : ea;
        eb_eff = (eb == 8'd0) ? 8'd1 : eb;
        ma = {ea != 8'd0, a[22:0]};
        mb = {eb != 8'd0, b[22:0]};
`else
        ea_eff = ea;
        eb_eff = eb;
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
`endif
        a_ge_b = {ea_eff, ma} >= {eb_eff, mb};
        sl = a_ge_b ? sa : sbe;
        el = a_ge_b ? ea_eff : eb_eff;
        es = a_ge_b ? eb_eff : ea_eff;
        ml = a_ge_b ? ma : mb;
        ms = a_ge_b ? mb : ma;
        d  = el - es;
        // Three extra bits below the LSB hold guard, round and sticky.
        sh_w = {ms, 3'b000, 27'd0} >> d;
        if (d >= 8'd27) ms_al = {26'd0, |ms};
        else            ms_al = {sh_w[53:28], sh_w[27] | (|sh_w[26:0])};

        special = nan_a || nan_b || inf_a || inf_b;
        if (nan_a || nan_b || (inf_a && inf_b && (sa != sbe))) spec_val = QNAN;
        else if (inf_a)                                      spec_val = {sa, 8'hFF, 23'd0};
        else                                                 spec_val = {sbe, 8'hFF, 23'd0};
    end

    logic        s1_valid;
    logic        s1_sign, s1_sub_op, s1_zero_sign, s1_special;
    logic [31:0] s1_spec_val;
    logic [7:0]  s1_exp;
    logic [26:0] s1_ml, s1_ms;

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= en;
        s1_sign      <= sl;
        s1_sub_op    <= sa ^ sbe;
        s1_zero_sign <= sa & sbe;
        s1_special   <= special;
        s1_spec_val  <= spec_val;
        s1_exp       <= el;
        s1_ml        <= {ml, 3'b000};
        s1_ms        <= ms_al;
    end

    // ---------------- stage 2: add/sub, leading-zero count, normalize -------
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [26:0] norm;
    logic [9:0]  exp_n;
    logic        sum_zero, flush, ovf;
    logic [7:0]  exp_field;

    always_comb begin
        if (s1_sub_op) sum = {1'b0, s1_ml} - {1'b0, s1_ms};
        else           sum = {1'b0, s1_ml} + {1'b0, s1_ms};
        lz = lzc27(sum[26:0]);
`ifdef FP_ADD_DENORM_EN
        // Stop left shifts at exponent 1 so tiny results come out already denormalized.
        sh = ({3'b000, lz} < s1_exp) ? lz : 5'(s1_exp - 8'd1);
`else
        sh = lz;
`endif
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, s1_exp} + 10'd1;
        end else begin
            norm  = sum[26:0] << sh;
            exp_n = {2'b00, s1_exp} - {5'd0, sh};
        end
        sum_zero  = (sum == 28'd0);
        flush     = exp_n[9] || (exp_n == 10'd0);
        ovf       = !exp_n[9] && (exp_n >= 10'd255);
        exp_field = norm[26] ? exp_n[7:0] : 8'd0;
    end

    logic        s2_valid;
    logic        s2_sign, s2_zero, s2_zero_sign, s2_flush, s2_ovf, s2_special;
    logic [31:0] s2_spec_val;
    logic [7:0]  s2_exp;
    logic [25:0] s2_mant;

    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else     s2_valid <= s1_valid;
        s2_sign      <= s1_sign;
        s2_zero      <= sum_zero;
        s2_zero_sign <= s1_zero_sign;
        s2_flush     <= flush;
        s2_ovf       <= ovf;
        s2_special   <= s1_special;
        s2_spec_val  <= s1_spec_val;
        s2_exp       <= exp_field;
        s2_mant      <= norm[25:0];
    end

    // ---------------- stage 3: round to nearest even, pack ------------------
    logic        rnd;
    logic [30:0] packed_mag;
    logic [31:0] res3;

    always_comb begin
        rnd = s2_mant[2] && (s2_mant[1] || s2_mant[0] || s2_mant[3]);
        // Rounding carry ripples into the exponent: covers renormalization,
        // denormal-to-normal promotion and overflow to infinity.
        packed_mag = {s2_exp, s2_mant[25:3]} + {30'd0, rnd};
        if (s2_special)    res3 = s2_spec_val;
        else if (s2_zero)  res3 = {s2_zero_sign, 31'd0};
        else if (s2_flush) res3 = {s2_sign, 31'd0};
        else if (s2_ovf)   res3 = {s2_sign, 8'hFF, 23'd0};
        else               res3 = {s2_sign, packed_mag};
    end

    logic [31:0] tail_y;
    logic        tail_v;

    generate
        if (LAT <= 3) begin : g_nodly
            assign tail_y = res3;
            assign tail_v = s2_valid;
        end else begin : g_dly
            logic [31:0] dly_y [1:LAT-3];
            logic        dly_v [1:LAT-3];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 1; i <= LAT - 3; i++) dly_v[i] <= 1'b0;
                end else begin
                    dly_v[1] <= s2_valid;
                    for (int i = 2; i <= LAT - 3; i++) dly_v[i] <= dly_v[i-1];
                end
                dly_y[1] <= res3;
                for (int i = 2; i <= LAT - 3; i++) dly_y[i] <= dly_y[i-1];
            end
            assign tail_y = dly_y[LAT-3];
            assign tail_v = dly_v[LAT-3];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= 32'd0;
            valid <= 1'b0;
        end else begin
            valid <= tail_v;
            if (tail_v) y <= tail_y;
        end
    end

endmodule

// File: tb/tb_fp_add.sv
// Directed self-checking bench for fp_add: reset, add/sub, rounding, specials,
// back-to-back throughput, reset mid-flight and denormal handling.
`timescale 1ns/1ps
`ifndef FP_ADD_LAT
`define FP_ADD_LAT 3
`endif

module tb_fp_add;

    localparam int LAT = `FP_ADD_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        sub, en;
    logic [31:0] y;
    logic        valid;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    fp_add #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .en(en), .y(y), .valid(valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op, then wait (bounded) for valid; returns result and latency (0 = none).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                          output logic [31:0] got, output int lat);
        @(negedge clk);
        a = ta; b = tbv; sub = ts; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat = 0;
        got = 32'hxxxx_xxxx;
        for (int n = 1; n <= LAT + 4; n++) begin
            if (valid) begin
                lat = n;
                got = y;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (y !== 32'd0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: y=%h valid=%b expected y=00000000 valid=0", y, valid);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b expected 0", valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] got;
        int lat;
        run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, got, lat);
        checks++;
        if (got !== 32'h4040_0000 || lat != LAT) begin
            failures++;
            $display("FAIL basic_add: y=%h lat=%0d expected y=40400000 lat=%0d", got, lat, LAT);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || y !== 32'h4040_0000) begin
            failures++;
            $display("FAIL basic_hold: y=%h valid=%b expected y=40400000 valid=0", y, valid);
        end
        run_op(32'h40A0_0000, 32'h4020_0000, 1'b1, got, lat);
        checks++;
        if (got !== 32'h4020_0000 || lat != LAT) begin
            failures++;
            $display("FAIL basic_sub: y=%h lat=%0d expected y=40200000 lat=%0d", got, lat, LAT);
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va[9], vb[9], vy[9];
        logic        vs[9];
        logic [31:0] got;
        int lat;
        va = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000,
               32'h3F80_0001, 32'h3F80_0000, 32'hBFC0_0000, 32'h0000_0000};
        vb = '{32'h3380_0000, 32'h3440_0000, 32'h3F80_0000, 32'h8000_0000, 32'h3380_0001,
               32'h3380_0000, 32'h3F7F_FFFF, 32'h3F00_0000, 32'h8000_0000};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vy = '{32'h3F80_0000, 32'h3F80_0002, 32'h0000_0000, 32'h8000_0000, 32'h3F80_0001,
               32'h3F80_0002, 32'h3380_0000, 32'hBF80_0000, 32'h0000_0000};
        for (int i = 0; i < 9; i++) begin
            run_op(va[i], vb[i], vs[i], got, lat);
            checks++;
            if (got !== vy[i] || lat != LAT) begin
                failures++;
                $display("FAIL rounding[%0d]: y=%h lat=%0d expected y=%h lat=%0d",
                         i, got, lat, vy[i], LAT);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[9], vb[9], vy[9];
        logic        vs[9];
        logic [31:0] got;
        int lat;
        va = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h7F80_0001, 32'h7F80_0000, 32'h3F80_0000,
               32'h7F7F_FFFF, 32'hFF80_0000, 32'h4049_0FDB, 32'hC049_0FDB};
        vb = '{32'h7F80_0000, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000,
               32'h7300_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};
        vs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vy = '{32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000,
               32'h7F80_0000, 32'h7FC0_0000, 32'h4049_0FDB, 32'hC049_0FDB};
        for (int i = 0; i < 9; i++) begin
            run_op(va[i], vb[i], vs[i], got, lat);
            checks++;
            if (got !== vy[i] || lat != LAT) begin
                failures++;
                $display("FAIL specials[%0d]: y=%h lat=%0d expected y=%h lat=%0d",
                         i, got, lat, vy[i], LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops[3];
        logic [31:0] exp_v;
        int got_cnt;
        ops = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        exp_q.delete();
        exp_q.push_back(32'h4000_0000);
        exp_q.push_back(32'h4080_0000);
        exp_q.push_back(32'h40C0_0000);
        got_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = ops[i]; b = ops[i]; sub = 1'b0; en = 1'b1;
        end
        @(negedge clk);
        en = 1'b0;
        // Negedge n lies in the cycle n after the first issue cycle.
        for (int n = 3; n <= LAT + 6; n++) begin
            if (valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: unexpected valid at cycle %0d y=%h expected none", n, y);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (y !== exp_v || n != LAT + got_cnt) begin
                        failures++;
                        $display("FAIL b2b_result[%0d]: y=%h cycle=%0d expected y=%h cycle=%0d",
                                 got_cnt, y, n, exp_v, LAT + got_cnt);
                    end
                    got_cnt++;
                end
            end
            if (n == LAT + 3) begin
                checks++;
                if (valid !== 1'b0 || y !== 32'h40C0_0000) begin
                    failures++;
                    $display("FAIL b2b_bubble: y=%h valid=%b expected y=40c00000 valid=0", y, valid);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_missing: %0d results outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] got;
        int lat;
        int rises;
        @(negedge clk);
        a = 32'h3F80_0000; b = 32'h3F80_0000; sub = 1'b0; en = 1'b1;
        @(negedge clk);
        a = 32'h4000_0000; b = 32'h4000_0000;
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (y !== 32'd0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_reset: y=%h valid=%b expected y=00000000 valid=0", y, valid);
        end
        rises = 0;
        for (int n = 0; n < LAT + 3; n++) begin
            @(negedge clk);
            if (valid) rises++;
        end
        checks++;
        if (rises != 0 || y !== 32'd0) begin
            failures++;
            $display("FAIL midflight_discard: valid_rises=%0d y=%h expected 0 rises y=00000000", rises, y);
        end
        run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, got, lat);
        checks++;
        if (got !== 32'h4080_0000 || lat != LAT) begin
            failures++;
            $display("FAIL midflight_fresh: y=%h lat=%0d expected y=40800000 lat=%0d", got, lat, LAT);
        end
    endtask

    task automatic test_denorm();
        logic [31:0] got;
        int lat;
        logic [31:0] e1, e2;
`ifdef FP_ADD_DENORM_EN
        e1 = 32'h0000_0001;
        e2 = 32'h007F_FFFF;
`else
        e1 = 32'h0000_0000;
        e2 = 32'h0080_0000;
`endif
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, got, lat);
        checks++;
        if (got !== e1 || lat != LAT) begin
            failures++;
            $display("FAIL denorm_add: y=%h lat=%0d expected y=%h lat=%0d", got, lat, e1, LAT);
        end
        run_op(32'h0080_0000, 32'h0000_0001, 1'b1, got, lat);
        checks++;
        if (got !== e2 || lat != LAT) begin
            failures++;
            $display("FAIL denorm_sub: y=%h lat=%0d expected y=%h lat=%0d", got, lat, e2, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_reset_midflight();
        test_denorm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
